// File: rtl/pwm_pkg.sv
// Shared helpers for the PWM compare stage: wrap detection and full-scale
// arithmetic usable with any counter width.
package pwm_pkg;

    // Reference counter width for the stage and its bench.
    localparam int unsigned PWM_DEFAULT_WIDTH = 32'd3;

    // Number of counts in one period of a WIDTH-bit up counter.
    function automatic int unsigned full_scale(input int unsigned width);
        return 32'd1 << width;
    endfunction

    // A wrap is the all-ones count followed directly by zero; a counter
    // parked at zero never produces one.
    function automatic logic is_wrap(input logic [31:0] prev,
                                     input logic [31:0] cur,
                                     input logic [31:0] all_ones);
        return (prev == all_ones) && (cur == 32'd0);
    endfunction

endpackage

// File: rtl/pwm_deadtime_gen.sv
// Dead-band generator: delays the compare result by one register and
// blanks both outputs for DEAD_CYCLES clocks after every transition, so
// the true and complementary outputs are never high together.
module pwm_deadtime_gen
    import pwm_pkg::*;
#(
    parameter int unsigned DEAD_CYCLES = 32'd1
) (
    input  logic clk,
    input  logic rst,
    input  logic cmp_i,
    input  logic started_i,
    output logic pwm_o,
    output logic pwm_n_o
);

    // Down-counter wide enough for DEAD_CYCLES, never narrower than one bit.
    localparam int unsigned DW = (DEAD_CYCLES > 32'd0) ? $clog2(DEAD_CYCLES + 32'd1) : 32'd1;
    localparam logic [DW-1:0] DEAD_LOAD = DW'(DEAD_CYCLES);

    logic          raw_q,   raw_d;
    logic [DW-1:0] dead_q,  dead_d;
    logic          pwm_q,   pwm_d;
    logic          pwm_n_q, pwm_n_d;
    logic          idle_s;

    // Next-state: restart the dead band on any change of the compare result.
    always_comb begin
        raw_d  = cmp_i;
        dead_d = dead_q;
        idle_s = (dead_q == {DW{1'b0}});
        if (cmp_i != raw_q) begin
            dead_d = DEAD_LOAD;
        end else if (!idle_s) begin
            dead_d = dead_q - DW'(1'b1);
        end else begin
            dead_d = dead_q;
        end
        pwm_d   = raw_q & idle_s;
        pwm_n_d = started_i & ~raw_q & idle_s;
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            raw_q   <= 1'b0;
            dead_q  <= {DW{1'b0}};
            pwm_q   <= 1'b0;
            pwm_n_q <= 1'b0;
        end else begin
            raw_q   <= raw_d;
            dead_q  <= dead_d;
            pwm_q   <= pwm_d;
            pwm_n_q <= pwm_n_d;
        end
    end

    assign pwm_o   = pwm_q;
    assign pwm_n_o = pwm_n_q;

endmodule

// File: rtl/pwm_compare_stage.sv
// PWM compare stage: compares a free-running up counter with a duty value
// that is shadowed through a valid/ready handshake and only takes effect at
// counter wrap. Produces registered PWM / complementary outputs, a
// per-period tick and an "applied" pulse.
// Optional build macro PWM_DEADTIME_EN inserts a dead band of DEAD_CYCLES
// clocks around every output transition (pwm_deadtime_gen).
module pwm_compare_stage
    import pwm_pkg::*;
#(
    parameter int unsigned WIDTH       = PWM_DEFAULT_WIDTH,
    parameter int unsigned DEAD_CYCLES = 32'd1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] cnt_in,
    input  logic             cfg_valid,
    input  logic [WIDTH:0]   cfg_duty,
    output logic             cfg_ready,
    output logic             cfg_applied,
    output logic             period_tick,
    output logic             pwm_out,
    output logic             pwm_n_out
);

    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

    // Dead band longer than a period is not a meaningful configuration;
    // this block only exists to make such a setting visible in elaboration.
    if (DEAD_CYCLES >= full_scale(WIDTH)) begin : g_dead_cycles_out_of_range
    end

    logic [WIDTH-1:0] cnt_prev_q,  cnt_prev_d;
    logic             started_q,   started_d;
    logic             pend_q,      pend_d;
    logic [WIDTH:0]   duty_pend_q, duty_pend_d;
    logic [WIDTH:0]   duty_act_q,  duty_act_d;
    logic             applied_q,   applied_d;
    logic             tick_q,      tick_d;

    logic             wrap_s;
    logic             accept_s;
    logic             apply_s;
    logic             started_s;
    logic [WIDTH:0]   duty_sel_s;
    logic             cmp_s;

    // Wrap detection, handshake, shadow apply and the compare itself.
    // started_s includes the wrap cycle so count 0 of the first full period
    // is already driven.
    always_comb begin
        wrap_s     = is_wrap(32'(cnt_prev_q), 32'(cnt_in), 32'(ALL_ONES));
        accept_s   = cfg_valid & ~pend_q;
        apply_s    = wrap_s & pend_q;
        started_s  = started_q | wrap_s;
        duty_sel_s = apply_s ? duty_pend_q : duty_act_q;
        cmp_s      = started_s & ({1'b0, cnt_in} < duty_sel_s);

        cnt_prev_d  = cnt_in;
        started_d   = started_s;
        tick_d      = wrap_s;
        applied_d   = apply_s;
        duty_act_d  = duty_act_q;
        duty_pend_d = duty_pend_q;
        pend_d      = pend_q;
        if (apply_s) begin
            duty_act_d = duty_pend_q;
            pend_d     = 1'b0;
        end else if (accept_s) begin
            duty_pend_d = cfg_duty;
            pend_d      = 1'b1;
        end else begin
            pend_d = pend_q;
        end
    end

    // Control and shadow registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_prev_q  <= {WIDTH{1'b0}};
            started_q   <= 1'b0;
            pend_q      <= 1'b0;
            duty_pend_q <= {(WIDTH+1){1'b0}};
            duty_act_q  <= {(WIDTH+1){1'b0}};
            applied_q   <= 1'b0;
            tick_q      <= 1'b0;
        end else begin
            cnt_prev_q  <= cnt_prev_d;
            started_q   <= started_d;
            pend_q      <= pend_d;
            duty_pend_q <= duty_pend_d;
            duty_act_q  <= duty_act_d;
            applied_q   <= applied_d;
            tick_q      <= tick_d;
        end
    end

    assign cfg_ready   = ~pend_q;
    assign cfg_applied = applied_q;
    assign period_tick = tick_q;

`ifdef PWM_DEADTIME_EN
    pwm_deadtime_gen #(
        .DEAD_CYCLES (DEAD_CYCLES)
    ) u_deadtime (
        .clk       (clk),
        .rst       (rst),
        .cmp_i     (cmp_s),
        .started_i (started_q),
        .pwm_o     (pwm_out),
        .pwm_n_o   (pwm_n_out)
    );
`else
    logic pwm_q,   pwm_d;
    logic pwm_n_q, pwm_n_d;

    // Output next-state: direct compare and its started-gated complement.
    always_comb begin
        pwm_d   = cmp_s;
        pwm_n_d = started_s & ~cmp_s;
    end

    // Output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pwm_q   <= 1'b0;
            pwm_n_q <= 1'b0;
        end else begin
            pwm_q   <= pwm_d;
            pwm_n_q <= pwm_n_d;
        end
    end

    assign pwm_out   = pwm_q;
    assign pwm_n_out = pwm_n_q;
`endif

endmodule

// File: tb/tb_pwm_compare_stage.sv
// Bench for pwm_compare_stage (WIDTH=3): cycle model of the period/duty
// rules, a table of duty values with expected high time, hand sequences for
// back-to-back loads and reset with a pending duty, then random traffic.
module tb_pwm_compare_stage;

    localparam int P = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [2:0] cnt_in = 3'd0;
    logic       cfg_valid = 1'b0;
    logic [3:0] cfg_duty = 4'd0;
    logic       cfg_ready, cfg_applied, period_tick, pwm_out, pwm_n_out;

    pwm_compare_stage #(.WIDTH(3), .DEAD_CYCLES(1)) dut (
        .clk(clk), .rst(rst), .cnt_in(cnt_in), .cfg_valid(cfg_valid),
        .cfg_duty(cfg_duty), .cfg_ready(cfg_ready), .cfg_applied(cfg_applied),
        .period_tick(period_tick), .pwm_out(pwm_out), .pwm_n_out(pwm_n_out));

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state (integers, period-level rules).
    int m_prev, m_act, m_pend;
    bit m_started, m_pend_v;
    bit m_tick, m_applied, m_pwm, m_pwmn, m_ready;

    // Source / counter stimulus state.
    bit src_req = 1'b0;
    int src_val = 0;
    bit cnt_en  = 1'b1;

    typedef struct {
        int duty;
        int exp_high;
    } vec_t;
    vec_t vecs[8];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_prev = 0; m_act = 0; m_pend = 0;
        m_started = 1'b0; m_pend_v = 1'b0;
        m_tick = 1'b0; m_applied = 1'b0; m_pwm = 1'b0; m_pwmn = 1'b0;
        m_ready = 1'b1;
    endtask

    // One clock: predict from current inputs, clock, compare, drive next inputs.
    task automatic step();
        int c, dsel;
        bit wrap, apply, st, hi, acc;
        c     = int'(cnt_in);
        wrap  = (m_prev == P - 1) && (c == 0);
        apply = wrap && m_pend_v;
        dsel  = apply ? m_pend : m_act;
        st    = m_started || wrap;
        hi    = st && (c < dsel);
        acc   = cfg_valid && !m_pend_v;
        m_tick = wrap; m_applied = apply; m_pwm = hi; m_pwmn = st && !hi;
        if (apply) begin
            m_act = m_pend; m_pend_v = 1'b0;
        end else if (acc) begin
            m_pend = int'(cfg_duty); m_pend_v = 1'b1;
        end
        m_started = st; m_prev = c; m_ready = !m_pend_v;
        @(posedge clk); #1;
        check("period_tick", int'(period_tick), int'(m_tick));
        check("cfg_applied", int'(cfg_applied), int'(m_applied));
        check("cfg_ready",   int'(cfg_ready),   int'(m_ready));
`ifdef PWM_DEADTIME_EN
        check("pwm_overlap", int'(pwm_out & pwm_n_out), 0);
`else
        check("pwm_out",     int'(pwm_out),     int'(m_pwm));
        check("pwm_n_out",   int'(pwm_n_out),   int'(m_pwmn));
`endif
        if (acc) src_req = 1'b0;
        cfg_valid = src_req;
        cfg_duty  = 4'(src_val);
        if (cnt_en) cnt_in = cnt_in + 3'd1;
    endtask

    task automatic request(input int v);
        src_req = 1'b1; src_val = v;
        cfg_valid = 1'b1; cfg_duty = 4'(v);
    endtask

    // Run until the model sees a duty applied (bounded), then measure one period.
    task automatic measure_period(input string name, input int exp_high);
        int n, hi, lo;
        n = 0;
        while (!m_applied && n < 40) begin
            step(); n++;
        end
        if (!m_applied) check({name, "_apply_timeout"}, 0, 1);
        hi = int'(pwm_out); lo = int'(pwm_n_out);
        for (int i = 1; i < P; i++) begin
            step();
            hi += int'(pwm_out); lo += int'(pwm_n_out);
        end
`ifndef PWM_DEADTIME_EN
        check({name, "_high_clks"}, hi, exp_high);
        check({name, "_low_clks"},  lo, P - exp_high);
`endif
    endtask

    initial begin
        int ticks, applies, hi;
        vecs[0] = '{3, 3};  vecs[1] = '{8, 8};  vecs[2] = '{9, 8};
        vecs[3] = '{0, 0};  vecs[4] = '{5, 5};  vecs[5] = '{1, 1};
        vecs[6] = '{15, 8}; vecs[7] = '{7, 7};
        model_reset();

        // Reset state.
        repeat (2) @(negedge clk);
        check("rst_pwm",     int'(pwm_out), 0);
        check("rst_pwm_n",   int'(pwm_n_out), 0);
        check("rst_tick",    int'(period_tick), 0);
        check("rst_applied", int'(cfg_applied), 0);
        check("rst_ready",   int'(cfg_ready), 1);
        @(posedge clk); #1;
        rst = 1'b1;

        // First period with no config: outputs low until the wrap, then
        // pwm_n high from count 0; tick every 8 cycles.
        for (int i = 0; i < P; i++) step();
        check("pre_wrap_pwm_n", int'(pwm_n_out), 0);
        ticks = 0;
        for (int i = 0; i < 3 * P; i++) begin
            step();
            ticks += int'(period_tick);
        end
        check("tick_count", ticks, 3);
        check("idle_pwm_n", int'(pwm_n_out), 1);

        // Duty table, each loaded mid-period.
        for (int k = 0; k < 8; k++) begin
            repeat (3) step();
            request(vecs[k].duty);
            step();
            check("ready_after_load", int'(cfg_ready), 0);
            measure_period($sformatf("duty%0d", vecs[k].duty), vecs[k].exp_high);
        end

        // Back-to-back 5 then 2: second stalls, nothing lost.
        repeat (2) step();
        request(5);
        step();
        request(2);
        step();
        check("b2b_stall_ready", int'(cfg_ready), 0);
        check("b2b_valid_held",  int'(cfg_valid), 1);
        measure_period("b2b_first", 5);
        measure_period("b2b_second", 2);

        // Reset mid-period with a pending duty: no stale apply afterwards.
        repeat (2) step();
        request(6);
        repeat (2) step();
        rst = 1'b0;
        src_req = 1'b0; cfg_valid = 1'b0;
        #1;
        check("midrst_pwm",   int'(pwm_out), 0);
        check("midrst_pwm_n", int'(pwm_n_out), 0);
        check("midrst_ready", int'(cfg_ready), 1);
        model_reset();
        repeat (3) begin
            @(posedge clk); #1;
            cnt_in = cnt_in + 3'd1;
        end
        rst = 1'b1;
        applies = 0; hi = 0;
        for (int i = 0; i < 3 * P; i++) begin
            step();
            applies += int'(cfg_applied);
            hi += int'(pwm_out);
        end
        check("midrst_no_apply", applies, 0);
        check("midrst_duty0",    hi, 0);

        // Random traffic, including occasional counter holds.
        for (int i = 0; i < 600; i++) begin
            if (!src_req && $urandom_range(0, 5) == 0) request(int'($urandom_range(0, 15)));
            cnt_en = ($urandom_range(0, 9) != 0);
            step();
        end
        cnt_en = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pwm_compare_stage.md
Name: pwm_compare_stage

Overview:
- Downstream consumer of the free-running N-bit up counter.
- Compares the counter value against a programmable duty threshold and produces a registered PWM output, plus a registered complementary output.
- The duty value is loaded via a valid/ready handshake into a shadow register. It is applied only at counter wrap, so no period ever contains a glitched or partial duty.
- Also emits a once-per-period tick for downstream timing.

Parameters:
- WIDTH, 3: counter width in bits; period = 2**WIDTH cycles.
- DEAD_CYCLES, 1: dead-time length in clocks; used only with PWM_DEADTIME_EN; legal range 0..(2**WIDTH)-1.

Ports:
- clk  input  1  rising-edge clock, shared with counter
- rst  input  1  asynchronous active-low reset
- cnt_in  input  WIDTH  counter value from upstream up counter
- cfg_valid  input  1  duty update request
- cfg_duty  input  WIDTH+1  requested high-time in counts
- cfg_ready  output  1  shadow register free; transfer when cfg_valid & cfg_ready
- cfg_applied  output  1  one-cycle pulse: pending duty became active
- period_tick  output  1  one-cycle pulse per counter wrap
- pwm_out  output  1  PWM output
- pwm_n_out  output  1  complementary PWM output

Behaviour:
- Reset (rst low, async) forces the following:
  - cfg_applied, period_tick, pwm_out and pwm_n_out to 0.
  - duty_act_q, duty_pend_q and cnt_prev_q to 0.
  - pend_q to 0.
  - cfg_ready reads 1.
  - started_q to 0.
- Reset mid-period discards any pending duty. Outputs resume low until the first wrap after reset.
- Wrap detect:
  - cnt_prev_q registers cnt_in every cycle.
  - wrap_evt = (cnt_prev_q == all-ones) & (cnt_in == 0).
  - started_q sets on the first wrap_evt; a counter held at 0 produces no wrap.
- Handshake:
  - cfg_ready = ~pend_q (combinational from a register).
  - On accept: duty_pend_q <= cfg_duty, pend_q <= 1.
  - cfg_valid while cfg_ready=0 is held off and not dropped. The source keeps cfg_duty stable until accepted.
- Apply:
  - When wrap_evt & pend_q: duty_act_q <= duty_pend_q, pend_q <= 0, cfg_applied pulses the next cycle.
  - If accept and wrap coincide with pend_q=0, the new value becomes pending and applies at the following wrap.
- Compare:
  - duty_sel = (wrap_evt & pend_q) ? duty_pend_q : duty_act_q, so a new duty governs count 0 of the new period.
  - cmp = started_q & (({1'b0,cnt_in}) < duty_sel).
  - duty_sel = 0 gives always low; duty_sel >= 2**WIDTH gives always high (100%).
- Latency:
  - pwm_out is cmp registered, one cycle after cnt_in.
  - period_tick is wrap_evt registered, one cycle after the wrap cycle.
- Width rules:
  - All compares are unsigned on WIDTH+1 bits.
  - cnt_in is zero-extended.
  - No arithmetic overflow is possible.

Optional Feature:
- Macro: PWM_DEADTIME_EN.
- Without the macro:
  - pwm_out <= cmp and pwm_n_out <= started_q & ~cmp.
  - There is no dead band.
  - DEAD_CYCLES is ignored.
- With the macro:
  - A registered raw_q <= cmp is added, plus a down-counter dead_q of width $clog2(DEAD_CYCLES+1), minimum 1.
  - When cmp != raw_q, dead_q loads DEAD_CYCLES.
  - Otherwise dead_q decrements to 0 and saturates there.
  - pwm_out <= raw_q & (dead_q==0) and pwm_n_out <= started_q & ~raw_q & (dead_q==0).
  - Both outputs are low for DEAD_CYCLES clocks after every transition and are never high together.
  - DEAD_CYCLES=0 behaves as without the macro, plus one extra cycle of latency.

Decomposition:
- Package pwm_pkg holds:
  - typedef duty_t (logic [WIDTH:0] via parameterised usage), or localparam helpers.
  - function is_wrap(prev, cur).
  - localparam FULL_SCALE = 2**WIDTH.
- One natural sub-module: pwm_deadtime_gen, containing raw_q, dead_q and output gating. It is instantiated only under PWM_DEADTIME_EN.

Test Plan (WIDTH=3, driven by an N-bit up counter, default DEAD_CYCLES=1):
- Reset, then counter runs 0..7 with no config -> pwm_out=0, pwm_n_out=0 until the first wrap; afterwards pwm_out stays 0 and pwm_n_out is 1 from count 0 of the second period; period_tick pulses once every 8 cycles.
- Load duty=3 mid-period -> cfg_ready drops for that period; at wrap, cfg_applied pulses; pwm_out is high for 3 clocks then low for 5, every period.
- Load duty=8, then duty=9 -> pwm_out stays high for the whole period and pwm_n_out stays low; duty=0 afterwards gives a constant low.
- Two back-to-back cfg_valid values (5 then 2) -> the second stalls (cfg_ready=0) until the wrap applies 5; 2 applies one period later; no value is lost.
- Assert rst mid-period with a pending duty -> outputs go 0 immediately and pend_q clears; after release, the old duty remains 0 (no stale apply).
- With PWM_DEADTIME_EN and DEAD_CYCLES=1, duty=4 -> each edge shows one cycle with both outputs low; pwm_out & pwm_n_out is never 1.
